// File: rtl/idu_exu_buf_if.sv
// -----------------------------------------------------------------------------
// idu_exu_buf_if
// Handshake and payload bundle between the decode unit (IDU), the two-entry
// operand buffer and the execute stage (EXU).
//
//   IDU side : in_valid / in_ready handshake, decoded operands, operand
//              selects, ALU control codes and writeback tag.
//   EXU side : out_valid / out_ready handshake, resolved operands, PC,
//              ALU control codes and writeback tag.
//   Status   : occupancy (entries held, 0..2).
//
// Modports:
//   slave  - the buffer (consumes in_*, produces out_*).
//   master - the environment driving the buffer (IDU + EXU).
// -----------------------------------------------------------------------------
interface idu_exu_buf_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_rs1_data;
    logic [XLEN-1:0] in_rs2_data;
    logic [XLEN-1:0] in_imm;
    logic            in_src1_sel;
    logic            in_src2_sel;
    logic [3:0]      in_func_control;
    logic [3:0]      in_inner_control;
    logic [4:0]      in_rd;
    logic            in_rd_wen;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_src1;
    logic [XLEN-1:0] out_src2;
    logic [XLEN-1:0] out_pc;
    logic [3:0]      out_func_control;
    logic [3:0]      out_inner_control;
    logic [4:0]      out_rd;
    logic            out_rd_wen;

    logic [1:0]      occupancy;

    modport slave (
        input  in_valid, in_pc, in_rs1_data, in_rs2_data, in_imm,
               in_src1_sel, in_src2_sel, in_func_control, in_inner_control,
               in_rd, in_rd_wen, out_ready,
        output in_ready, out_valid, out_src1, out_src2, out_pc,
               out_func_control, out_inner_control, out_rd, out_rd_wen,
               occupancy
    );

    modport master (
        output in_valid, in_pc, in_rs1_data, in_rs2_data, in_imm,
               in_src1_sel, in_src2_sel, in_func_control, in_inner_control,
               in_rd, in_rd_wen, out_ready,
        input  in_ready, out_valid, out_src1, out_src2, out_pc,
               out_func_control, out_inner_control, out_rd, out_rd_wen,
               occupancy
    );
endinterface

// File: rtl/idu_exu_buf.sv
// -----------------------------------------------------------------------------
// idu_exu_buf
// Two-entry operand buffer between IDU and EXU. ALU operands are resolved at
// enqueue (src1 = rs1 or PC, src2 = rs2 or immediate) and stored together with
// the ALU control codes and writeback tag. All outputs come from registered
// state only; in_ready never depends on out_ready.
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset (clears pointers, count and entries)
//   flush - synchronous flush, drops all buffered entries (beats push/pop)
//   bus   - idu_exu_buf_if.slave handshake/payload bundle
// -----------------------------------------------------------------------------
module idu_exu_buf #(
    parameter int XLEN = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    idu_exu_buf_if.slave  bus
);
    logic [XLEN-1:0] src1_mem  [2];
    logic [XLEN-1:0] src2_mem  [2];
    logic [XLEN-1:0] pc_mem    [2];
    logic [3:0]      func_mem  [2];
    logic [3:0]      inner_mem [2];
    logic [4:0]      rd_mem    [2];
    logic            wen_mem   [2];

    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;

    logic            push;
    logic            pop;
    logic [XLEN-1:0] src1_val;
    logic [XLEN-1:0] src2_val;

    // rst_n gates only the visible ready; while reset is low the state
    // registers are held cleared, so push need not see it.
    assign push = bus.in_valid && (count != 2'd2);
    assign pop  = bus.out_ready && (count != 2'd0);

    assign src1_val = bus.in_src1_sel ? bus.in_pc  : bus.in_rs1_data;
    assign src2_val = bus.in_src2_sel ? bus.in_imm : bus.in_rs2_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Entries are cleared only by reset; a flush just rewinds the pointers,
    // and a push in the flush cycle is not written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                src1_mem[i]  <= '0;
                src2_mem[i]  <= '0;
                pc_mem[i]    <= '0;
                func_mem[i]  <= '0;
                inner_mem[i] <= '0;
                rd_mem[i]    <= '0;
                wen_mem[i]   <= 1'b0;
            end
        end else if (push && !flush) begin
            src1_mem[wr_ptr]  <= src1_val;
            src2_mem[wr_ptr]  <= src2_val;
            pc_mem[wr_ptr]    <= bus.in_pc;
            func_mem[wr_ptr]  <= bus.in_func_control;
            inner_mem[wr_ptr] <= bus.in_inner_control;
            rd_mem[wr_ptr]    <= bus.in_rd;
            wen_mem[wr_ptr]   <= bus.in_rd_wen;
        end
    end

    assign bus.in_ready          = (count != 2'd2) && rst_n;
    assign bus.out_valid         = (count != 2'd0);
    assign bus.out_src1          = src1_mem[rd_ptr];
    assign bus.out_src2          = src2_mem[rd_ptr];
    assign bus.out_pc            = pc_mem[rd_ptr];
    assign bus.out_func_control  = func_mem[rd_ptr];
    assign bus.out_inner_control = inner_mem[rd_ptr];
    assign bus.out_rd            = rd_mem[rd_ptr];
    assign bus.out_rd_wen        = wen_mem[rd_ptr];
    assign bus.occupancy         = count;
endmodule

// File: tb/tb_idu_exu_buf.sv
// -----------------------------------------------------------------------------
// tb_idu_exu_buf
// Self-checking bench for idu_exu_buf: a table of directed cycle vectors,
// hand-written streaming and asynchronous-reset sequences, and randomized
// traffic compared against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_idu_exu_buf;
    logic clk;
    logic rst_n;
    logic flush;

    idu_exu_buf_if #(.XLEN(64)) bus ();

    idu_exu_buf #(.XLEN(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] src1;
        logic [63:0] src2;
        logic [63:0] pc;
        logic [3:0]  func;
        logic [3:0]  inner;
        logic [4:0]  rd;
        logic        rd_wen;
    } ent_t;

    ent_t q[$];

    typedef struct {
        logic        vld;
        logic        s1;
        logic        s2;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [3:0]  func;
        logic        ordy;
        logic        fl;
        logic        e_vld;
        logic [1:0]  e_occ;
        logic        e_rdy;
        logic [63:0] e_src1;
        logic [63:0] e_src2;
        logic [3:0]  e_func;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic vld, input logic s1, input logic s2,
                         input logic [63:0] rs1, input logic [63:0] rs2,
                         input logic [63:0] pc, input logic [63:0] imm,
                         input logic [3:0] func, input logic ordy, input logic fl);
        bus.in_valid         = vld;
        bus.in_src1_sel      = s1;
        bus.in_src2_sel      = s2;
        bus.in_rs1_data      = rs1;
        bus.in_rs2_data      = rs2;
        bus.in_pc            = pc;
        bus.in_imm           = imm;
        bus.in_func_control  = func;
        bus.in_inner_control = ~func;
        bus.in_rd            = rs1[4:0];
        bus.in_rd_wen        = rs1[0];
        bus.out_ready        = ordy;
        flush                = fl;
    endtask

    // Reference model: a FIFO of at most two resolved entries, advanced with
    // the inputs present just before the clock edge.
    task automatic tick();
        ent_t e;
        bit   do_push;
        bit   do_pop;
        do_push  = bus.in_valid && (q.size() < 2);
        do_pop   = bus.out_ready && (q.size() > 0);
        e.src1   = bus.in_src1_sel ? bus.in_pc : bus.in_rs1_data;
        e.src2   = bus.in_src2_sel ? bus.in_imm : bus.in_rs2_data;
        e.pc     = bus.in_pc;
        e.func   = bus.in_func_control;
        e.inner  = bus.in_inner_control;
        e.rd     = bus.in_rd;
        e.rd_wen = bus.in_rd_wen;
        if (flush) begin
            q.delete();
        end else begin
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'(q.size() != 0));
        chk({tag, ".occupancy"}, 64'(bus.occupancy), 64'(q.size()));
        chk({tag, ".in_ready"},  64'(bus.in_ready),  64'(q.size() != 2));
        if (q.size() != 0) begin
            chk({tag, ".src1"},  bus.out_src1, q[0].src1);
            chk({tag, ".src2"},  bus.out_src2, q[0].src2);
            chk({tag, ".pc"},    bus.out_pc,   q[0].pc);
            chk({tag, ".func"},  64'(bus.out_func_control),  64'(q[0].func));
            chk({tag, ".inner"}, 64'(bus.out_inner_control), 64'(q[0].inner));
            chk({tag, ".rd"},    64'(bus.out_rd),     64'(q[0].rd));
            chk({tag, ".rd_wen"},64'(bus.out_rd_wen), 64'(q[0].rd_wen));
        end
    endtask

    initial begin
        //         vld   s1    s2    rs1     rs2     pc             imm     func  ordy  fl  | e_vld e_occ e_rdy e_src1        e_src2  e_func
        tbl[0]  = '{1'b1,1'b1,1'b1,64'd0, 64'd0, 64'h8000_0000,64'h10, 4'd6,1'b0,1'b0, 1'b1,2'd1,1'b1,64'h8000_0000,64'h10,4'd6};
        tbl[1]  = '{1'b0,1'b0,1'b0,64'd0, 64'd0, 64'd0,        64'd0,  4'd0,1'b1,1'b0, 1'b0,2'd0,1'b1,64'd0,        64'd0, 4'd0};
        tbl[2]  = '{1'b1,1'b0,1'b0,64'd1, 64'd2, 64'h100,      64'h55, 4'd0,1'b0,1'b0, 1'b1,2'd1,1'b1,64'd1,        64'd2, 4'd0};
        tbl[3]  = '{1'b1,1'b0,1'b0,64'd3, 64'd4, 64'h104,      64'd0,  4'd1,1'b0,1'b0, 1'b1,2'd2,1'b0,64'd1,        64'd2, 4'd0};
        tbl[4]  = '{1'b1,1'b0,1'b0,64'd9, 64'd9, 64'd0,        64'd0,  4'd2,1'b0,1'b0, 1'b1,2'd2,1'b0,64'd1,        64'd2, 4'd0};
        tbl[5]  = '{1'b0,1'b0,1'b0,64'd0, 64'd0, 64'd0,        64'd0,  4'd0,1'b1,1'b0, 1'b1,2'd1,1'b1,64'd3,        64'd4, 4'd1};
        tbl[6]  = '{1'b0,1'b0,1'b0,64'd0, 64'd0, 64'd0,        64'd0,  4'd0,1'b1,1'b0, 1'b0,2'd0,1'b1,64'd0,        64'd0, 4'd0};
        tbl[7]  = '{1'b1,1'b0,1'b1,64'd5, 64'd6, 64'd0,        64'h20, 4'd4,1'b0,1'b0, 1'b1,2'd1,1'b1,64'd5,        64'h20,4'd4};
        tbl[8]  = '{1'b1,1'b1,1'b0,64'd7, 64'd8, 64'h200,      64'd0,  4'd5,1'b1,1'b0, 1'b1,2'd1,1'b1,64'h200,      64'd8, 4'd5};
        tbl[9]  = '{1'b1,1'b0,1'b0,64'd10,64'd11,64'd0,        64'd0,  4'd3,1'b0,1'b0, 1'b1,2'd2,1'b0,64'h200,      64'd8, 4'd5};
        tbl[10] = '{1'b1,1'b0,1'b0,64'd12,64'd12,64'd0,        64'd0,  4'd7,1'b1,1'b1, 1'b0,2'd0,1'b1,64'd0,        64'd0, 4'd0};
        tbl[11] = '{1'b1,1'b0,1'b0,64'd13,64'd14,64'd0,        64'd0,  4'd1,1'b0,1'b0, 1'b1,2'd1,1'b1,64'd13,       64'd14,4'd1};
        tbl[12] = '{1'b0,1'b0,1'b0,64'd0, 64'd0, 64'd0,        64'd0,  4'd0,1'b1,1'b0, 1'b0,2'd0,1'b1,64'd0,        64'd0, 4'd0};

        // Reset state
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0, 4'd0, 1'b0, 1'b0);
        #1;
        chk("rst.in_ready",  64'(bus.in_ready),  64'd0);
        chk("rst.out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst.occupancy", 64'(bus.occupancy), 64'd0);
        chk("rst.out_src1",  bus.out_src1,       64'd0);
        #21;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel.in_ready",  64'(bus.in_ready),  64'd1);
        chk("rel.occupancy", 64'(bus.occupancy), 64'd0);

        // Directed cycle table
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].vld, tbl[i].s1, tbl[i].s2, tbl[i].rs1, tbl[i].rs2,
                  tbl[i].pc, tbl[i].imm, tbl[i].func, tbl[i].ordy, tbl[i].fl);
            tick();
            chk($sformatf("vec%0d.out_valid", i), 64'(bus.out_valid), 64'(tbl[i].e_vld));
            chk($sformatf("vec%0d.occupancy", i), 64'(bus.occupancy), 64'(tbl[i].e_occ));
            chk($sformatf("vec%0d.in_ready", i),  64'(bus.in_ready),  64'(tbl[i].e_rdy));
            if (tbl[i].e_vld) begin
                chk($sformatf("vec%0d.src1", i), bus.out_src1, tbl[i].e_src1);
                chk($sformatf("vec%0d.src2", i), bus.out_src2, tbl[i].e_src2);
                chk($sformatf("vec%0d.func", i), 64'(bus.out_func_control), 64'(tbl[i].e_func));
            end
        end

        // Streaming: one entry per cycle with out_ready held high
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 1'b0, 64'(i), 64'(i + 100), 64'd0, 64'd0, 4'd0, 1'b1, 1'b0);
            tick();
            chk($sformatf("stream%0d.out_valid", i), 64'(bus.out_valid), 64'd1);
            chk($sformatf("stream%0d.src1", i),      bus.out_src1,       64'(i));
            chk($sformatf("stream%0d.occupancy", i), 64'(bus.occupancy), 64'd1);
        end
        drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0, 4'd0, 1'b1, 1'b0);
        tick();
        check_model("stream_drain");

        // Asynchronous reset with two entries held
        drive(1'b1, 1'b0, 1'b0, 64'h11, 64'h22, 64'd0, 64'd0, 4'd1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 64'h33, 64'h44, 64'd0, 64'd0, 4'd2, 1'b0, 1'b0);
        tick();
        check_model("pre_rst");
        drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0, 4'd0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("midrst.out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst.in_ready",  64'(bus.in_ready),  64'd0);
        chk("midrst.out_src1",  bus.out_src1,       64'd0);
        chk("midrst.occupancy", 64'(bus.occupancy), 64'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk("midrel.in_ready",  64'(bus.in_ready),  64'd1);
        chk("midrel.occupancy", 64'(bus.occupancy), 64'd0);
        tick();
        check_model("post_rst");

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                  {$urandom, $urandom}, 4'($urandom_range(0, 7)),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
            tick();
            check_model($sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
